ip_fifo_rd_stream: RTL
======================

# ip_fifo_rd_stream

Read-side adapter for a single-clock FIFO read port with one-cycle read latency. It pops words from the FIFO and presents them as a valid/ready stream. A 2-entry output buffer absorbs the read latency, so the stream sustains one word per cycle and never loses a word under backpressure. It sits between a FIFO's `empty`/`rd_en`/`dout` port and any stream consumer, and also provides a synchronous flush and a handshake counter.

## Interface
- `WIDTH`, default 8: data word width.
- `CNT_W`, default 16: width of the delivered-word counter.

- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_rd_en`  out  1: FIFO pop request, sampled by the FIFO at the rising edge.
- `fifo_dout`  in  WIDTH: FIFO read data, valid in the cycle after the edge that sampled `fifo_rd_en`=1.
- `flush`  in  1: synchronous discard of buffered and in-flight words.
- `m_valid`  out  1: stream word available.
- `m_ready`  in  1: consumer accepts.
- `m_data`  out  WIDTH: stream word.
- `level`  out  2: buffered words, 0..2.
- `words_out`  out  CNT_W: count of completed stream handshakes.

## Operation
- State:
  - `buf0` and `buf1` (WIDTH each).
  - `level` (0..2).
  - `inflight` (1 bit): a read was issued at the previous edge.
  - `drop` (1 bit): the in-flight word must be discarded.
  - `words_out`.
- `m_valid` = (`level` != 0). `m_data` = `buf0`.
- `pop` = `m_valid` & `m_ready`.
- `fifo_rd_en` = !`rst` & !`flush` & !`fifo_empty` & ((`level` + `inflight` - `pop`) < 2).
  - This path is combinational from `m_ready` and `fifo_empty`.
  - Buffer occupancy plus outstanding reads never exceeds 2.
- Capture: when `inflight`=1 and `drop`=0, `fifo_dout` is written at the edge into slot (`level` - `pop`):
  - slot 0 → `buf0`, slot 1 → `buf1`.
- Pop: `buf0` <= `buf1` (unless the capture targets slot 0). Then `level` <= `level` - `pop` + capture.
- Simultaneous pop and capture at `level`=1: the new word goes directly to `buf0` and `level` stays 1.
- Simultaneous pop and capture at `level`=2: `buf0` <= `buf1`, `buf1` <= new word, `level` stays 2.
- `inflight` <= `fifo_rd_en`.
- `flush`=1 at an edge:
  - `level` <= 0.
  - `drop` <= `inflight` (the word arriving next cycle is discarded).
  - No pop is counted, even if `m_ready`=1.
  - `fifo_rd_en` is held 0 during the flush cycle.
- `drop` clears at the edge where the discarded word arrives.
- `words_out` increments by 1 on each `pop` and wraps modulo 2^CNT_W.
- FIFO contents are never touched except through `fifo_rd_en`. A flush only discards words already popped.

## Timing
- Reset (async assert, sync-edge deassert), effective immediately:
  - `level`=0, `inflight`=0, `drop`=0, `buf0`=`buf1`=0, `words_out`=0.
  - Hence `m_valid`=0, `m_data`=0, `fifo_rd_en`=0.
- Reset mid-operation: all buffered and in-flight words are lost. The FIFO is not reset by this block.
- Latency: `fifo_rd_en`=1 sampled at edge N; `fifo_dout` is valid in cycle N+1 and captured at edge N+1. `m_valid`=1 from cycle N+2. First word appears 2 cycles after `fifo_empty` falls.
- Throughput: 1 word/cycle with `m_ready` held 1 and the FIFO non-empty.
- Backpressure: with `m_ready`=0, at most 2 words are held and no further reads are issued. `m_data` and `m_valid` stay stable until accepted.
- `fifo_empty` rising stops issue in the same cycle. Words already in flight still complete.

## Test plan
- Reset, then FIFO holds 0x11,0x22,0x33 with `m_ready`=1:
  - `fifo_rd_en` pulses 3 consecutive cycles.
  - `m_data` shows 0x11,0x22,0x33 on consecutive cycles starting 2 cycles after the first `fifo_rd_en`.
  - `words_out`=3.
- FIFO holds 0xA0..0xA7 with `m_ready`=0 for 10 cycles:
  - `level`=2, `m_data`=0xA0 stable, only 2 `fifo_rd_en` pulses.
  - Then `m_ready`=1: 0xA0..0xA7 delivered in order, no gaps after the first.
- Random `m_ready` (50%) over 1000 random bytes:
  - Output sequence matches input exactly.
  - `level`+`inflight` never exceeds 2.
  - `words_out`=1000 mod 2^16.
- `flush` asserted the cycle after a read issue with `level`=1:
  - Buffered word and in-flight word are both discarded; `m_valid`=0 for 2 cycles.
  - The next FIFO word is delivered next with no corruption.
- `rst` asserted mid-stream with `level`=2 (async, no clock edge):
  - `m_valid`, `fifo_rd_en` and `words_out` go to 0 immediately.
  - After release, the remaining FIFO words stream out normally.
- `CNT_W`=4, 17 words delivered: `words_out` reads 1 after wrap.

Source files
------------

// File: rtl/ip_fifo_rd_stream.sv
// FIFO read-port to valid/ready stream adapter. A 2-entry output buffer hides
// the FIFO's one-cycle read latency so the stream runs at full rate.
module ip_fifo_rd_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             flush,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] words_out
);

  logic [WIDTH-1:0] buf0, buf1;
  logic             inflight, drop;
  logic             pop, capture;
  logic [1:0]       slot, committed;

  assign m_valid = (level != 2'd0);
  assign m_data  = buf0;
  // A flush cycle never completes a handshake.
  assign pop     = m_valid & m_ready & ~flush;
  assign capture = inflight & ~drop;
  assign slot    = level - {1'b0, pop};

  // Words held plus words already requested, after this cycle's pop.
  assign committed  = level + {1'b0, inflight} - {1'b0, pop};
  assign fifo_rd_en = ~rst & ~flush & ~fifo_empty & (committed < 2'd2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf0      <= '0;
      buf1      <= '0;
      level     <= 2'd0;
      inflight  <= 1'b0;
      drop      <= 1'b0;
      words_out <= '0;
    end else if (flush) begin
      // The word landing this edge is not captured; drop guards the next edge.
      level    <= 2'd0;
      drop     <= inflight;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      drop     <= 1'b0;
      if (pop) begin
        buf0      <= buf1;
        words_out <= words_out + CNT_W'(1);
      end
      // Capture after the shift so a slot-0 write wins over buf0 <= buf1.
      if (capture) begin
        if (slot == 2'd0) buf0 <= fifo_dout;
        else              buf1 <= fifo_dout;
      end
      level <= level - {1'b0, pop} + {1'b0, capture};
    end
  end

endmodule
